// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter feeding one shared modulus datapath from two frame buffers.
// One frame in flight: grant, stream FRAME_LEN samples, then hold until data_eop or timeout.
module fft_frame_arbiter #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ch0_req,
    output logic              ch0_gnt,
    output logic              ch0_rd_en,
    input  logic [DATA_W-1:0] ch0_real,
    input  logic [DATA_W-1:0] ch0_imag,
    input  logic              ch1_req,
    output logic              ch1_gnt,
    output logic              ch1_rd_en,
    input  logic [DATA_W-1:0] ch1_real,
    input  logic [DATA_W-1:0] ch1_imag,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] source_real,
    output logic [DATA_W-1:0] source_imag,
    output logic              source_sop,
    output logic              source_eop,
    output logic              source_valid,
    output logic              source_ch,
    input  logic              done_eop,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int                TCNT_W    = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t            state;
    logic              last_ch;
    logic              done_seen;
    logic              valid_seen;
    logic [TCNT_W-1:0] tcnt;
    logic              pick_ch;
    logic              rd_any;

    // Tie goes to the channel not served last; otherwise the lone requester wins.
    // NOTE: every combinational output gets a default path so no latch can be inferred.
    always_comb begin
        if (ch0_req && ch1_req) pick_ch = ~last_ch;
        else                    pick_ch = ch1_req;
    end

    assign rd_any = ch0_rd_en | ch1_rd_en;
    assign busy   = (state != IDLE);

    // Buffer data lands one cycle after rd_en, alongside the registered valid/sop/eop.
    assign source_real = source_valid ? (source_ch ? ch1_real : ch0_real) : '0;
    assign source_imag = source_valid ? (source_ch ? ch1_imag : ch0_imag) : '0;

    // NOTE: state uses non-blocking assignments only; later assignments in the block override earlier ones.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_ch      <= 1'b1;
            done_seen    <= 1'b0;
            valid_seen   <= 1'b0;
            tcnt         <= '0;
            ch0_gnt      <= 1'b0;
            ch1_gnt      <= 1'b0;
            ch0_rd_en    <= 1'b0;
            ch1_rd_en    <= 1'b0;
            rd_addr      <= '0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_valid <= 1'b0;
            source_ch    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err  <= 1'b0;
            source_valid <= rd_any;
            source_sop   <= rd_any && (rd_addr == '0);
            source_eop   <= rd_any && (rd_addr == LAST_ADDR);

            if (source_valid) valid_seen <= 1'b1;
            if (done_eop && (source_valid || valid_seen)) done_seen <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (en && (ch0_req || ch1_req)) begin
                        ch0_gnt   <= ~pick_ch;
                        ch1_gnt   <= pick_ch;
                        ch0_rd_en <= ~pick_ch;
                        ch1_rd_en <= pick_ch;
                        rd_addr   <= '0;
                        last_ch   <= pick_ch;
                        source_ch <= pick_ch;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_addr == LAST_ADDR) begin
                        ch0_rd_en <= 1'b0;
                        ch1_rd_en <= 1'b0;
                        rd_addr   <= '0;
                        tcnt      <= '0;
                        state     <= WAIT_DONE;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    // done takes priority over a coincident timeout
                    if (done_seen || done_eop || (tcnt == TCNT_LAST)) begin
                        timeout_err <= ~(done_seen || done_eop);
                        ch0_gnt     <= 1'b0;
                        ch1_gnt     <= 1'b0;
                        done_seen   <= 1'b0;
                        valid_seen  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
